// File: rtl/apb_uart_slave.sv
// apb_uart_slave: APB slave with a small TX FIFO feeding a UART transmitter.
// Define UART_PARITY_EN to append an even-parity bit to every frame.
module apb_uart_slave #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        TXD,
    output logic        IRQ
);
`ifdef UART_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          r_state, w_next;
    logic            r_ready;
    logic [1:0]      r_ctrl;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_count;
    logic [7:0]      r_data;
    logic [2:0]      r_bitcnt;
    logic [15:0]     r_clkcnt;
    logic            r_irq;
    logic [7:0]      w_off;
    logic            w_full, w_empty, w_access, w_err, w_push, w_pop, w_ctrl_wr, w_tick;
    logic [31:0]     w_status;
    logic            w_unused;

    assign w_off     = PADDR[7:0];
    assign w_full    = r_count == (AW+1)'(FIFO_DEPTH);
    assign w_empty   = r_count == '0;
    assign w_access  = PSEL & PENABLE & r_ready;
    assign w_err     = (|PADDR[1:0]) | (|PADDR[31:8])
                     | !(w_off == 8'h00 || w_off == 8'h04 || w_off == 8'h08)
                     | (!PWRITE && w_off == 8'h00)
                     | (PWRITE && w_off == 8'h04)
                     | (PWRITE && w_off == 8'h00 && w_full);
    assign w_push    = w_access & PWRITE & (w_off == 8'h00) & ~w_err;
    assign w_ctrl_wr = w_access & PWRITE & (w_off == 8'h08) & ~w_err;
    assign w_pop     = (r_state == S_IDLE) & r_ctrl[0] & ~w_empty;
    assign w_tick    = r_clkcnt == 16'(CLKS_PER_BIT - 1);
    assign w_status  = {23'd0, PAR, 5'(r_count), w_empty, w_full, r_state != S_IDLE};
    assign w_unused  = ^PWDATA[31:8];

    assign PREADY  = r_ready;
    assign PSLVERR = w_access & w_err;
    assign PRDATA  = (w_access && !PWRITE && !w_err) ?
                     (w_off == 8'h04 ? w_status : {30'd0, r_ctrl}) : 32'd0;
    assign TXD     = (r_state == S_START)  ? 1'b0 :
                     (r_state == S_DATA)   ? r_data[r_bitcnt] :
                     (r_state == S_PARITY) ? ^r_data : 1'b1;
    assign IRQ     = r_irq;

    // Exactly one wait state: PREADY rises on the second access cycle only.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_ready <= 1'b0;
            r_ctrl  <= 2'b00;
        end else begin
            r_ready <= PSEL & PENABLE & ~r_ready;
            if (w_ctrl_wr)
                r_ctrl <= PWDATA[1:0];
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_push)
            r_mem[r_wptr] <= PWDATA[7:0];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_pop ? S_START : S_IDLE;
            S_START:  w_next = w_tick ? S_DATA : S_START;
            S_DATA:   w_next = (w_tick && r_bitcnt == 3'd7) ? (PAR ? S_PARITY : S_STOP) : S_DATA;
            S_PARITY: w_next = w_tick ? S_STOP : S_PARITY;
            S_STOP:   w_next = w_tick ? S_IDLE : S_STOP;
            default:  w_next = S_IDLE;
        endcase
    end

    // The byte is held whole; the bit counter selects which bit drives TXD.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_data   <= 8'd0;
            r_bitcnt <= 3'd0;
            r_clkcnt <= 16'd0;
            r_irq    <= 1'b0;
        end else begin
            r_irq <= r_ctrl[1] & w_empty & (r_state == S_IDLE);
            if (w_pop) begin
                r_data   <= r_mem[r_rptr];
                r_bitcnt <= 3'd0;
                r_clkcnt <= 16'd0;
            end else if (r_state != S_IDLE) begin
                r_clkcnt <= w_tick ? 16'd0 : r_clkcnt + 16'd1;
                if (r_state == S_DATA && w_tick)
                    r_bitcnt <= r_bitcnt + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_apb_uart_slave.sv
// tb_apb_uart_slave: directed plus randomized bench for apb_uart_slave.
// Expected frames and STATUS words come from a byte queue and the frame format.
module tb_apb_uart_slave;
    localparam int C     = 16;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam logic PAR = 1'b1;
    localparam int   NB  = 11;
`else
    localparam logic PAR = 1'b0;
    localparam int   NB  = 10;
`endif

    logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR, TXD, IRQ;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] q[$];

    apb_uart_slave #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .TXD(TXD), .IRQ(IRQ)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] st(input int cnt, input logic busy);
        return (32'(PAR) << 8) | (32'(cnt) << 3) | (32'(cnt == 0) << 2)
             | (32'(cnt == DEPTH) << 1) | 32'(busy);
    endfunction

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        int n;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        chk("pready_first", PREADY, 0);
        n = 0;
        do begin
            @(posedge PCLK); #1;
            n++;
        end while (PREADY !== 1'b1 && n < 8);
        chk("wait_states", n, 1);
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        chk("pready_after", PREADY, 0);
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic e);
        logic [31:0] r;
        logic        er;
        apb(1'b1, a, d, r, er);
        chk({tag, "_err"}, er, e);
        chk({tag, "_prdata"}, r, 0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp, input logic e);
        logic [31:0] r;
        logic        er;
        apb(1'b0, a, $urandom, r, er);
        chk({tag, "_err"}, er, e);
        chk({tag, "_data"}, r, exp);
    endtask

    task automatic push(input string tag, input logic [7:0] b, input logic e);
        wr(tag, 32'h0, {$urandom_range(0, 32'hffffff), b}, e);
        if (!e) q.push_back(b);
    endtask

    task automatic wait_fall(input string tag);
        int n = 0;
        while (TXD !== 1'b0 && n < 400) begin
            @(posedge PCLK); #1;
            n++;
        end
        chk({tag, "_start"}, TXD, 0);
    endtask

    // Samples the first and last cycle of every bit slot of one frame.
    task automatic frame(input string tag, input logic [7:0] b);
        logic [10:0] exp_f, first, last;
        exp_f = PAR ? {1'b1, ^b, b, 1'b0} : {1'b0, 1'b1, b, 1'b0};
        first = '0;
        last  = '0;
        wait_fall(tag);
        for (int c = 0; c < NB * C; c++) begin
            if (c > 0) begin
                @(posedge PCLK); #1;
            end
            if (c % C == 0) first[c / C] = TXD;
            if (c % C == C - 1) last[c / C] = TXD;
        end
        chk({tag, "_bits_first"}, 32'(first), 32'(exp_f));
        chk({tag, "_bits_last"}, 32'(last), 32'(exp_f));
        @(posedge PCLK); #1;
        chk({tag, "_idle"}, TXD, 1);
    endtask

    // Times a TXDATA write so it commits on the same edge as the FIFO pop.
    task automatic race(input int k, input logic exp_err);
        int c0, exp_cnt;
        push("race_first", 8'($urandom), 1'b0);
        wait_fall("race");
        c0 = cyc;
        void'(q.pop_front());
        for (int i = 0; i < k; i++) push("race_fill", 8'($urandom), 1'b0);
        while (cyc < c0 + NB * C - 3) begin
            @(posedge PCLK); #1;
        end
        push("race_push", 8'($urandom), exp_err);
        if (q.size() > 0) void'(q.pop_front());
        exp_cnt = exp_err ? k - 1 : k;
        chk("race_model_cnt", q.size(), exp_cnt);
        rd("race_status", 32'h4, st(exp_cnt, 1'b1), 1'b0);
        repeat ((exp_cnt + 1) * (NB * C + 1) + 20) @(posedge PCLK);
        #1;
        q.delete();
        rd("race_drained", 32'h4, st(0, 1'b0), 1'b0);
    endtask

    initial begin
        logic [7:0]  b, b2;
        logic [31:0] d;
        int          k;
        logic        bad;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'd0; PWDATA = 32'd0;
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_txd", TXD, 1);
        chk("rst_pready", PREADY, 0);
        chk("rst_pslverr", PSLVERR, 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_irq", IRQ, 0);
        PRESETn = 1'b1;

        rd("status_reset", 32'h4, st(0, 1'b0), 1'b0);
        rd("ctrl_reset", 32'h8, 32'h0, 1'b0);

        rd("rd_misaligned", 32'h2, 32'h0, 1'b1);
        rd("rd_unmapped", 32'hC, 32'h0, 1'b1);
        rd("rd_txdata", 32'h0, 32'h0, 1'b1);
        wr("wr_status", 32'h4, 32'h3, 1'b1);
        wr("wr_ctrl_hiaddr", 32'h108, 32'h3, 1'b1);
        wr("wr_ctrl_misal", 32'h9, 32'h3, 1'b1);
        rd("ctrl_unchanged", 32'h8, 32'h0, 1'b0);
        rd("status_unchanged", 32'h4, st(0, 1'b0), 1'b0);

        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            wr("ctrl_rand", 32'h8, d, 1'b0);
            rd("ctrl_rand_rb", 32'h8, {30'd0, d[1:0]}, 1'b0);
        end
        wr("ctrl_clear", 32'h8, 32'h0, 1'b0);

        for (int i = 0; i < 5; i++) push("fill", 8'($urandom), i == 4);
        rd("status_full", 32'h4, st(DEPTH, 1'b0), 1'b0);
        wr("ctrl_en", 32'h8, 32'h1, 1'b0);
        while (q.size() > 0) frame("drain", q.pop_front());
        rd("status_drained", 32'h4, st(0, 1'b0), 1'b0);

        push("a5", 8'hA5, 1'b0);
        frame("a5", q.pop_front());
        rd("status_a5", 32'h4, st(0, 1'b0), 1'b0);

        for (int r = 0; r < 3; r++) begin
            wr("round_dis", 32'h8, 32'h0, 1'b0);
            k = $urandom_range(1, DEPTH);
            for (int i = 0; i < k; i++) push("round_push", 8'($urandom), 1'b0);
            rd("round_status", 32'h4, st(k, 1'b0), 1'b0);
            wr("round_en", 32'h8, 32'h1, 1'b0);
            while (q.size() > 0) frame("round", q.pop_front());
        end

        wr("midfr_dis", 32'h8, 32'h0, 1'b0);
        b  = 8'($urandom);
        b2 = 8'($urandom);
        push("midfr_b1", b, 1'b0);
        push("midfr_b2", b2, 1'b0);
        wr("midfr_en", 32'h8, 32'h1, 1'b0);
        wait_fall("midfr");
        wr("midfr_clear", 32'h8, 32'h0, 1'b0);
        repeat (NB * C + 10) @(posedge PCLK);
        #1;
        chk("midfr_idle_txd", TXD, 1);
        rd("midfr_status", 32'h4, st(1, 1'b0), 1'b0);
        wr("midfr_reen", 32'h8, 32'h1, 1'b0);
        frame("midfr_b2", b2);
        q.delete();
        rd("midfr_empty", 32'h4, st(0, 1'b0), 1'b0);

        race(DEPTH, 1'b1);
        race(2, 1'b0);

        wr("irq_en", 32'h8, 32'h3, 1'b0);
        @(posedge PCLK); #1;
        chk("irq_high", IRQ, 1);
        push("irq_push", 8'h00, 1'b0);
        @(posedge PCLK); #1;
        chk("irq_fall", IRQ, 0);
        frame("irq_frame", q.pop_front());
        chk("irq_stop_end", IRQ, 0);
        @(posedge PCLK); #1;
        chk("irq_rise", IRQ, 1);
        wr("irq_dis", 32'h8, 32'h1, 1'b0);
        @(posedge PCLK); #1;
        chk("irq_off", IRQ, 0);

        push("rst_byte", 8'($urandom), 1'b0);
        wait_fall("rst_frame");
        repeat (4 * C + C / 2) @(posedge PCLK);
        #1;
        PRESETn = 1'b0;
        #1;
        chk("midrst_txd", TXD, 1);
        chk("midrst_pready", PREADY, 0);
        chk("midrst_irq", IRQ, 0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        q.delete();
        bad = 1'b0;
        repeat (20) begin
            @(posedge PCLK); #1;
            if (TXD !== 1'b1) bad = 1'b1;
        end
        chk("postrst_txd_idle", bad, 0);
        rd("postrst_status", 32'h4, st(0, 1'b0), 1'b0);
        rd("postrst_ctrl", 32'h8, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_uart_slave.md
APB_UART_SLAVE -- requirements
Module: apb_uart_slave

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, PCLK cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, TX FIFO entries (power of two, 2..16).
REQ-003 SHALL have port PCLK, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port PRESETn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports PSEL, PENABLE, PWRITE, each input, 1, APB select, enable and direction (1 = write).
REQ-006 SHALL have ports PADDR input 32 (address) and PWDATA input 32 (write data).
REQ-007 SHALL have ports PRDATA output 32 (read data), PREADY output 1 (transfer complete) and PSLVERR output 1 (error, valid only when PREADY=1).
REQ-008 SHALL have port TXD, output, 1, serial line; idles high.
REQ-009 SHALL have port IRQ, output, 1, level interrupt.

Function
REQ-010 SHALL decode PADDR[7:0]: 0x00 TXDATA (write-only; bits [7:0] pushed to FIFO), 0x04 STATUS (read-only), 0x08 CTRL (read/write; bit0 EN, bit1 IRQ_EN).
REQ-011 SHALL insert exactly one wait state on every access: first cycle with PSEL=PENABLE=1 drives PREADY=0, next cycle drives PREADY=1; PREADY SHALL be 0 at all other times.
REQ-012 SHALL commit writes and drive PRDATA only in the PREADY=1 cycle; PRDATA is 0 outside that cycle.
REQ-013 SHALL give PSLVERR=1 with PREADY=1 for: PADDR[1:0]!=0, PADDR[31:8]!=0, unmapped offset, read of TXDATA, write of STATUS, or TXDATA write while FIFO full; an erroring write SHALL change no state.
REQ-014 SHALL return STATUS = {bit0 BUSY (FSM not IDLE), bit1 FULL, bit2 EMPTY, bits[7:3] FIFO count}, all other bits 0; CTRL reads return bits [1:0], all other bits 0.
REQ-015 SHALL implement transmit FSM states IDLE, START, DATA, STOP; in IDLE with EN=1 and FIFO not empty, pop one byte and enter START on the next cycle.
REQ-016 SHALL hold each of START (TXD=0), eight DATA bits (LSB first), and STOP (TXD=1) for exactly CLKS_PER_BIT cycles, then return to IDLE; TXD=1 in IDLE.
REQ-017 SHALL let a frame in progress complete when EN is cleared mid-frame; no further pop while EN=0.
REQ-018 SHALL evaluate FULL on the pre-edge count: a push while full is rejected even when a pop occurs in the same cycle; push and pop on a non-full, non-empty FIFO in the same cycle SHALL leave count unchanged.
REQ-019 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.
REQ-020 SHALL drive IRQ = IRQ_EN & EMPTY & (FSM in IDLE), registered.

Reset
REQ-021 SHALL, while PRESETn=0, asynchronously force PRDATA=0, PREADY=0, PSLVERR=0, TXD=1, IRQ=0, CTRL=0, FIFO empty, pointers 0, bit counter 0, FSM IDLE.
REQ-022 SHALL abort any frame and any APB transfer in progress on reset; after release TXD stays 1 until a new byte is popped.

Configuration
REQ-023 SHALL, when macro UART_PARITY_EN is defined, add a PARITY state between DATA and STOP that sends the even parity of the 8 data bits for CLKS_PER_BIT cycles (11-cycle-bit frame); STATUS bit8 reads 1.
REQ-024 SHALL, when UART_PARITY_EN is undefined, send 10-bit frames with no parity state; STATUS bit8 reads 0.

Verification
REQ-025 Write CTRL=0x1, write TXDATA=0xA5, CLKS_PER_BIT=16 -> each access PREADY low 1 cycle then high; TXD shows 0,1,0,1,0,0,1,0,1,1 at 16-cycle spacing, BUSY returns to 0.
REQ-026 With EN=0, write 5 bytes, FIFO_DEPTH=4 -> writes 1-4 PSLVERR=0, write 5 PSLVERR=1, STATUS reads 0x0000_0022 (FULL, count=4).
REQ-027 Read PADDR=0x0000_0002 and PADDR=0x0000_000C -> PSLVERR=1, PRDATA=0, no register change.
REQ-028 Write CTRL=0x3 with FIFO empty -> IRQ=1; push 0x00 -> IRQ falls within 2 cycles and rises again after the STOP bit ends.
REQ-029 Assert PRESETn=0 during DATA bit 3 of a frame -> TXD=1, PREADY=0, STATUS reads 0x0000_0004 after release.
REQ-030 With UART_PARITY_EN defined, send 0x07 -> parity bit 1 after bit 7, frame 176 cycles long.
